// File: rtl/bsg_source_sync_calib_seq_pkg.sv
// Shared types and helpers for the source-synchronous calibration sequencer.
package bsg_source_sync_calib_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREPARE,
    RUN,
    NEXT,
    DONE,
    FAIL
  } calib_seq_state_e;

  // Lowest non-bypassed test index strictly above cur; tests (activation) if none remain.
  // Call with cur = -1 to find the first test of a sequence.
  function automatic int next_test_index(input int cur, input int tests, input logic [31:0] bypass);
    int r;
    r = tests;
    for (int i = 31; i >= 0; i--) begin
      if (i > cur && i < tests && !bypass[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/bsg_source_sync_calib_seq_timer.sv
// Free-running up-counter, cleared on demand, flagging the prepare-hold and RUN-timeout limits.
module bsg_source_sync_calib_seq_timer #(
  parameter int lg_prepare_hold_cycles_p = 6,
  parameter int lg_timeout_cycles_p      = 12
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic prepare_tc_o,
  output logic timeout_tc_o
);

  localparam int width_lp = (lg_prepare_hold_cycles_p > lg_timeout_cycles_p)
                            ? lg_prepare_hold_cycles_p : lg_timeout_cycles_p;

  logic [width_lp-1:0] count_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      count_r <= '0;
    else if (clear_i) count_r <= '0;
    else              count_r <= count_r + width_lp'(1);
  end

  assign prepare_tc_o = (count_r == width_lp'((1 << lg_prepare_hold_cycles_p) - 1));
  assign timeout_tc_o = (count_r == width_lp'((1 << lg_timeout_cycles_p) - 1));

endmodule

// File: rtl/bsg_source_sync_calib_sequencer.sv
// Steps the channel-control master through each non-bypassed calibration test, then activation.
// Optional per-index timeout retry: define BSG_SOURCE_SYNC_CALIB_SEQ_RETRY_EN.
module bsg_source_sync_calib_sequencer
  import bsg_source_sync_calib_seq_pkg::*;
#(
  parameter int               tests_p                  = 5,
  parameter int               lg_prepare_hold_cycles_p = 6,
  parameter int               lg_timeout_cycles_p      = 12,
  parameter logic [tests_p-1:0] bypass_test_p          = '0,
  parameter int               max_retries_p            = 3
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic [tests_p:0]                   test_pass_i,
  output logic [$clog2(tests_p+1)-1:0]       calibration_state_o,
  output logic                               calib_prepare_o,
  output logic                               channel_active_o,
  output logic                               done_o,
  output logic                               error_o,
  output logic [$clog2(max_retries_p+1)-1:0] retry_count_o
);

  localparam int idx_w_lp     = $clog2(tests_p+1);
  localparam int retry_w_lp   = $clog2(max_retries_p+1);
  localparam int first_idx_lp = next_test_index(-1, tests_p, 32'(bypass_test_p));

  calib_seq_state_e      state_r, state_n;
  logic [idx_w_lp-1:0]   idx_r, idx_n;
  logic [retry_w_lp-1:0] retry_r, retry_n;
  logic                  prepare_tc, timeout_tc;

  // Any state change restarts the count, so each PREPARE and RUN is timed from zero.
  bsg_source_sync_calib_seq_timer #(
    .lg_prepare_hold_cycles_p(lg_prepare_hold_cycles_p),
    .lg_timeout_cycles_p     (lg_timeout_cycles_p)
  ) timer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (state_n != state_r),
    .prepare_tc_o(prepare_tc),
    .timeout_tc_o(timeout_tc)
  );

  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    retry_n = retry_r;
    case (state_r)
      IDLE, DONE, FAIL: begin
        if (start_i) begin
          state_n = PREPARE;
          idx_n   = idx_w_lp'(first_idx_lp);
          retry_n = '0;
        end
      end
      PREPARE: if (prepare_tc) state_n = RUN;
      RUN: begin
        // A pass seen on the terminal timeout cycle takes priority.
        if (test_pass_i[idx_r]) begin
          state_n = (idx_r == idx_w_lp'(tests_p)) ? DONE : NEXT;
        end else if (timeout_tc) begin
`ifdef BSG_SOURCE_SYNC_CALIB_SEQ_RETRY_EN
          if (retry_r < retry_w_lp'(max_retries_p)) begin
            retry_n = retry_r + retry_w_lp'(1);
            state_n = PREPARE;
          end else begin
            state_n = FAIL;
          end
`else
          state_n = FAIL;
`endif
        end
      end
      NEXT: begin
        idx_n   = idx_w_lp'(next_test_index(int'(idx_r), tests_p, 32'(bypass_test_p)));
        retry_n = '0;
        state_n = PREPARE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r          <= IDLE;
      idx_r            <= '0;
      retry_r          <= '0;
      calib_prepare_o  <= 1'b1;
      channel_active_o <= 1'b0;
      done_o           <= 1'b0;
      error_o          <= 1'b0;
    end else begin
      state_r          <= state_n;
      idx_r            <= idx_n;
      retry_r          <= retry_n;
      calib_prepare_o  <= (state_n == IDLE) || (state_n == PREPARE) || (state_n == FAIL);
      channel_active_o <= (state_n == DONE);
      done_o           <= (state_n == DONE);
      error_o          <= (state_n == FAIL);
    end
  end

  assign calibration_state_o = idx_r;
  assign retry_count_o       = retry_r;

endmodule

// File: tb/tb_bsg_source_sync_calib_sequencer.sv
// Directed bench for the calibration sequencer, plus two bypass-configured instances.
module tb_bsg_source_sync_calib_sequencer;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [5:0] test_pass;
  logic [5:0] pass_all = 6'h3f;

  logic [2:0] cal_state, cal_state_b, cal_state_a;
  logic       prep, prep_b, prep_a;
  logic       active, active_b, active_a;
  logic       done, done_b, done_a;
  logic       err, err_b, err_a;
  logic [1:0] retry, retry_b, retry_a;

  int checks = 0;
  int errors = 0;
  int qb[$];
  int qa[$];

  always #5 clk = ~clk;

  bsg_source_sync_calib_sequencer dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .test_pass_i(test_pass),
    .calibration_state_o(cal_state), .calib_prepare_o(prep), .channel_active_o(active),
    .done_o(done), .error_o(err), .retry_count_o(retry));

  bsg_source_sync_calib_sequencer #(.bypass_test_p(5'b10110)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .test_pass_i(pass_all),
    .calibration_state_o(cal_state_b), .calib_prepare_o(prep_b), .channel_active_o(active_b),
    .done_o(done_b), .error_o(err_b), .retry_count_o(retry_b));

  bsg_source_sync_calib_sequencer #(.bypass_test_p(5'b11111)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .test_pass_i(pass_all),
    .calibration_state_o(cal_state_a), .calib_prepare_o(prep_a), .channel_active_o(active_a),
    .done_o(done_a), .error_o(err_a), .retry_count_o(retry_a));

  // Record each distinct index the bypass instances run.
  always @(posedge clk) begin
    #1;
    if (prep_b === 1'b0 && (qb.size() == 0 || qb[$] != int'(cal_state_b))) qb.push_back(int'(cal_state_b));
    if (prep_a === 1'b0 && (qa.size() == 0 || qa[$] != int'(cal_state_a))) qa.push_back(int'(cal_state_a));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idx"}, 32'(cal_state), 0);
    chk({tag, "_prep"}, 32'(prep), 1);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_retry"}, 32'(retry), 0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  // Called on the sample where PREPARE has just been entered; returns on the first RUN sample.
  task automatic wait_run(input int idx);
    int n;
    n = 0;
    chk("prep_idx", 32'(cal_state), idx);
    while (prep === 1'b1 && n < 200) begin
      n++;
      step(1);
    end
    chk("prep_len", n, 64);
    chk("run_idx", 32'(cal_state), idx);
  endtask

  task automatic run_idx(input int idx, input bit last);
    wait_run(idx);
    step(2);
    test_pass[idx] = 1'b1;
    step(1);
    test_pass = '0;
    if (last) begin
      chk("done", 32'(done), 1);
      chk("active", 32'(active), 1);
      chk("done_prep", 32'(prep), 0);
      chk("done_idx", 32'(cal_state), 5);
    end else begin
      chk("next_prep", 32'(prep), 0);
      chk("next_idx", 32'(cal_state), idx);
      step(1);
    end
  endtask

  initial begin
    reset_i   = 1'b1;
    start_i   = 1'b0;
    test_pass = '0;
    step(2);
    chk_reset_vals("reset");
    reset_i = 1'b0;
    step(2);
    chk("idle_prep", 32'(prep), 1);

    // Nominal sequence through every index to activation.
    pulse_start();
    for (int i = 0; i < 5; i++) run_idx(i, 1'b0);
    run_idx(5, 1'b1);
    chk("done_err", 32'(err), 0);

    chk("byp_len", qb.size(), 3);
    chk("byp_0", (qb.size() > 0) ? qb[0] : -1, 0);
    chk("byp_1", (qb.size() > 1) ? qb[1] : -1, 3);
    chk("byp_2", (qb.size() > 2) ? qb[2] : -1, 5);
    chk("byp_done", 32'(done_b), 1);
    chk("allbyp_len", qa.size(), 1);
    chk("allbyp_0", (qa.size() > 0) ? qa[0] : -1, 5);
    chk("allbyp_done", 32'(active_a), 1);

    // Restart from DONE; start during RUN is ignored; pass on the terminal timeout cycle wins.
    pulse_start();
    chk("rst_done", 32'(done), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_idx", 32'(cal_state), 0);
    chk("rst_prep", 32'(prep), 1);
    wait_run(0);
    pulse_start();
    chk("ign_prep", 32'(prep), 0);
    chk("ign_idx", 32'(cal_state), 0);
    step(4094);
    test_pass[0] = 1'b1;
    step(1);
    test_pass = '0;
    chk("race_prep", 32'(prep), 0);
    chk("race_err", 32'(err), 0);
    chk("race_retry", 32'(retry), 0);
    chk("race_idx", 32'(cal_state), 0);
    step(1);
    chk("race_adv_prep", 32'(prep), 1);
    chk("race_adv_idx", 32'(cal_state), 1);
    run_idx(1, 1'b0);

    // Index 2 never passes.
    wait_run(2);
`ifdef BSG_SOURCE_SYNC_CALIB_SEQ_RETRY_EN
    for (int r = 1; r <= 3; r++) begin
      step(4095);
      chk("retry_wait_err", 32'(err), 0);
      step(1);
      chk("retry_cnt", 32'(retry), r);
      chk("retry_prep", 32'(prep), 1);
      chk("retry_err", 32'(err), 0);
      wait_run(2);
    end
    step(4096);
    chk("tmo_retry", 32'(retry), 3);
`else
    step(4095);
    chk("tmo_wait_err", 32'(err), 0);
    chk("tmo_wait_prep", 32'(prep), 0);
    step(1);
    chk("tmo_retry", 32'(retry), 0);
`endif
    chk("tmo_err", 32'(err), 1);
    chk("tmo_prep", 32'(prep), 1);
    chk("tmo_idx", 32'(cal_state), 2);
    chk("tmo_done", 32'(done), 0);

    // Restart from FAIL, then async reset in the middle of index 3's RUN.
    pulse_start();
    chk("rf_err", 32'(err), 0);
    chk("rf_retry", 32'(retry), 0);
    chk("rf_idx", 32'(cal_state), 0);
    for (int i = 0; i < 3; i++) run_idx(i, 1'b0);
    wait_run(3);
    step(5);
    chk("mid_prep", 32'(prep), 0);
    reset_i = 1'b1;
    #1;
    chk_reset_vals("async");
    step(2);
    reset_i = 1'b0;
    step(1);
    pulse_start();
    chk("post_idx", 32'(cal_state), 0);
    chk("post_prep", 32'(prep), 1);
    wait_run(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_source_sync_calib_sequencer.md
# bsg_source_sync_calib_sequencer

Calibration sequencer that sits directly upstream of the source-synchronous channel-control master, in the output-channel clock domain. It steps the calibration index through each non-bypassed test, then the final activation pseudo-test. For each index it pulses the prepare (reset) window for a fixed hold time and waits for the master's per-test pass bit, with a timeout. Its outputs drive the master's calibration-state and prepare inputs; its status outputs report link activation or failure to the core.

## Interface
- `tests_p`, 5: number of real tests; index `tests_p` is the activation pseudo-test.
- `lg_prepare_hold_cycles_p`, 6: prepare window is 2^p cycles.
- `lg_timeout_cycles_p`, 12: RUN timeout is 2^p cycles.
- `bypass_test_p`, 5'b0: bit i=1 skips test i; width `tests_p`; the activation index is never bypassed.
- `max_retries_p`, 3: timeouts tolerated per index (only with retry enabled).
- `clk_i` in 1: output-channel clock; the only clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: begin or restart calibration; level-sampled.
- `test_pass_i` in `tests_p+1`: per-index pass bits from the channel-control master.
- `calibration_state_o` out `$clog2(tests_p+1)`: current test index.
- `calib_prepare_o` out 1: prepare/reset to the master.
- `channel_active_o` out 1: link calibrated and active.
- `done_o` out 1: sequence completed successfully.
- `error_o` out 1: sequence failed.
- `retry_count_o` out `$clog2(max_retries_p+1)`: retries used on the current index.

## Operation
- **Reset values:** FSM=IDLE, `calibration_state_o`=0, `calib_prepare_o`=1, `channel_active_o`=0, `done_o`=0, `error_o`=0, `retry_count_o`=0.
- **FSM states:** IDLE, PREPARE, RUN, NEXT, DONE, FAIL.
- **IDLE:** `calib_prepare_o`=1. When `start_i`=1, load the index with the lowest non-bypassed test. If all tests are bypassed, load index `tests_p`. Then go to PREPARE.
- **PREPARE:** `calib_prepare_o`=1. Clear the counter on entry. After exactly 2^`lg_prepare_hold_cycles_p` cycles, go to RUN.
- **RUN:** `calib_prepare_o`=0 and the counter increments.
  - If `test_pass_i[index]`=1: go to NEXT; if index==`tests_p`, go to DONE instead.
  - Else, if the counter reaches 2^`lg_timeout_cycles_p`-1: timeout (see Configuration).
  - If pass and timeout occur in the same cycle, pass wins.
- **NEXT:** one cycle with `calib_prepare_o`=0.
  - Set index to the next higher non-bypassed index, or to `tests_p` if none remain.
  - Clear `retry_count_o`, then go to PREPARE.
- **DONE:** `channel_active_o`=1, `done_o`=1, `calib_prepare_o`=0, and the index holds at `tests_p`.
- **FAIL:** `error_o`=1, `calib_prepare_o`=1, and the index holds at the failing test.
- **Restart:** `start_i`=1 in DONE or FAIL clears `done_o`, `error_o`, `channel_active_o` and `retry_count_o`, then restarts exactly as from IDLE. `start_i` is ignored in PREPARE, RUN and NEXT.
- **Pass-bit sampling:** `test_pass_i` is sampled only in RUN. Bits from earlier indices are ignored.
- **Reset mid-operation:** asynchronous return to the reset values in the same cycle reset asserts.

## Timing
- `start_i` sampled high at edge T: PREPARE is entered at T+1, and `calib_prepare_o` stays 1 through T+2^H (H = `lg_prepare_hold_cycles_p`); RUN starts at T+2^H+1.
- Pass observed at edge N in RUN: NEXT at N+1, PREPARE for the new index at N+2.
- `calibration_state_o` changes only on entry to NEXT→PREPARE and on IDLE/restart. It is stable for the whole PREPARE and RUN of an index.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `BSG_SOURCE_SYNC_CALIB_SEQ_RETRY_EN`.
- **Defined:** on timeout, if `retry_count_o` < `max_retries_p`, increment `retry_count_o` and return to PREPARE with the same index; otherwise go to FAIL.
- **Undefined:** timeout goes directly to FAIL, and `retry_count_o` is tied to 0.

## Structure
- Package `bsg_source_sync_calib_seq_pkg`:
  - FSM state enum `calib_seq_state_e`;
  - the function computing the next non-bypassed index from the current index and the bypass mask.
- Sub-module `bsg_source_sync_calib_seq_timer`: loadable up-counter of width max(`lg_prepare_hold_cycles_p`, `lg_timeout_cycles_p`), with clear and terminal-count outputs for both limits.

## Test plan
- **Nominal run:** defaults; `start_i` pulse; assert `test_pass_i[i]` 3 cycles into each RUN → indices 0,1,2,3,4,5 in order; `calib_prepare_o` high for exactly 64 cycles per index; `done_o`=`channel_active_o`=1 after index 5 passes.
- **Bypass:** `bypass_test_p`=5'b10110 → the visited index sequence is 0,3,5. With 5'b11111 → first index is 5.
- **Timeout with retry:** retry macro defined; never pass index 2 → `retry_count_o` steps 1,2,3, then `error_o`=1 with `calibration_state_o`=2 and `calib_prepare_o`=1. Without the macro → `error_o` after the first 4096-cycle RUN.
- **Pass/timeout race:** pass asserted on the terminal timeout cycle → advance to NEXT, `retry_count_o` unchanged.
- **Async reset:** assert `reset_i` mid-RUN at index 3 → all outputs return to reset values immediately, with no clock edge needed; a later `start_i` restarts at index 0.
- **Restart:** `start_i` in DONE → `done_o`/`channel_active_o` drop and the sequence reruns from index 0; `start_i` during RUN → ignored.
